puf_cr_ctrl: RTL
================

Name: puf_cr_ctrl

Overview:
- Challenge/response sequencer between the UART block and the PUF core.
- Consumes one 64-bit challenge word from the UART receive stream and derives 64 sub-challenges from it.
- Evaluates each sub-challenge EVALS times on a 1-bit PUF and majority-votes the results into one response bit.
- Returns the 64-bit response word to the UART transmit stream.

Parameters:
- WIDTH, 64: challenge and response word width; also the number of response bits.
- EVALS, 5: evaluations per response bit. Must be odd, 1..15.
- TIMEOUT, 255: maximum WAIT cycles allowed per evaluation before it is abandoned.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  WIDTH  challenge word, driven from UART output_data.
- s_valid  in  1  challenge valid, from UART output_valid.
- s_ready  out  1  challenge accept, to UART output_ready.
- m_data  out  WIDTH  response word, to UART input_data.
- m_valid  out  1  response valid, to UART input_valid.
- m_ready  in  1  response accept, from UART input_ready.
- puf_challenge  out  WIDTH  registered challenge applied to the PUF.
- puf_start  out  1  one-cycle evaluation strobe.
- puf_done  in  1  PUF evaluation complete; puf_resp is valid in the same cycle.
- puf_resp  in  1  PUF response bit.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky flag: at least one evaluation timed out in the current or last transaction.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE. s_ready=1. m_valid=0, m_data=0, puf_start=0, puf_challenge=0, busy=0, timeout_err=0. All counters cleared.
- Reset asserted mid-transaction aborts it; the partial response is discarded and never sent.
- States: IDLE, APPLY, WAIT, SEND.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready: latch chal=s_data; clear bit_idx, eval_cnt, vote_cnt, resp, timeout_err; go to APPLY.
- APPLY (exactly 1 cycle):
  - Register puf_challenge = rotate-left(chal, bit_idx).
  - puf_start=1 for this cycle only; clear timer; go to WAIT.
- WAIT:
  - puf_challenge is held stable. puf_done is sampled only in WAIT; a puf_done seen in APPLY or IDLE is ignored.
  - If puf_done=1: r=puf_resp.
  - Else if timer==TIMEOUT-1: r=0 and timeout_err<=1.
  - Else timer++ and remain in WAIT.
  - Once r is resolved: vote=vote_cnt+r.
    - If eval_cnt<EVALS-1: vote_cnt<=vote, eval_cnt++, go to APPLY.
    - Otherwise: resp[bit_idx] <= (vote > EVALS/2); clear eval_cnt and vote_cnt.
    - Then, if bit_idx==WIDTH-1: go to SEND; else bit_idx++ and go to APPLY.
- SEND:
  - m_valid=1, m_data=resp, held stable until m_ready=1.
  - The cycle m_valid&m_ready is seen: m_valid<=0, go to IDLE.
  - s_ready=0 throughout, so a new challenge is back-pressured and never dropped.
- s_ready=0 in APPLY, WAIT and SEND.
- Bit mapping: response bit i comes from the sub-challenge chal rotated left by i; the voted result lands at m_data[i].
- Latency:
  - Minimum per evaluation is 2 cycles (APPLY, then WAIT with puf_done=1).
  - Minimum from challenge accept to m_valid is 2*EVALS*WIDTH+1 cycles (641 at defaults).
  - Worst case per evaluation is TIMEOUT+1 cycles.
- timeout_err stays set until the next challenge is accepted or reset is asserted.
- Counter widths: bit_idx is clog2(WIDTH); eval_cnt and vote_cnt are 4 bits; timer is clog2(TIMEOUT+1).

Test Plan:
- PUF model with puf_resp=1 and puf_done 3 cycles after puf_start; challenge 0x0123456789ABCDEF -> m_data=0xFFFFFFFFFFFFFFFF, timeout_err=0, exactly 320 puf_start pulses.
- PUF model with puf_resp=puf_challenge[63] and puf_done the cycle after puf_start; challenge 0x0000000000000001 -> m_data=0x8000000000000000; m_valid rises exactly 641 cycles after the accept edge.
- Majority vote: model returns 1,1,0,0,1 per bit -> m_data all ones. Model returns 1,0,0,1,0 -> m_data=0.
- puf_done tied to 0, TIMEOUT=8 -> m_data=0, timeout_err=1. Sending the next challenge clears timeout_err in its accept cycle.
- Backpressure: m_ready=0 for 100 cycles in SEND with s_valid=1 -> m_data stable, s_ready=0, no new accept. m_ready=1 -> one handshake, then IDLE with s_ready=1.
- Reset: rst low for 2 cycles during WAIT of bit 17 -> outputs at reset values immediately, no m_valid. A new challenge afterwards completes normally.

Source files
------------

// File: rtl/puf_cr_ctrl.sv
// Challenge/response sequencer: expands one challenge word into WIDTH rotated
// sub-challenges, majority-votes EVALS PUF evaluations per bit, returns the response word.
//   state | meaning
//   IDLE  | ready for a challenge word
//   APPLY | sub-challenge and start strobe presented to the PUF
//   WAIT  | waiting for puf_done or the per-evaluation timeout
//   SEND  | response word offered until accepted
module puf_cr_ctrl #(
    parameter int WIDTH   = 64,
    parameter int EVALS   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] puf_challenge,
    output logic             puf_start,
    input  logic             puf_done,
    input  logic             puf_resp,
    output logic             busy,
    output logic             timeout_err
);
    localparam int IDXW = $clog2(WIDTH);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, APPLY, WAIT, SEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] chal;
    logic [WIDTH-1:0] resp;
    logic [IDXW-1:0]  bit_idx;
    logic [3:0]       eval_cnt;
    logic [3:0]       vote_cnt;
    logic [TW-1:0]    timer;

    logic             r_ok;
    logic             r_bit;
    logic [3:0]       vote;
    logic             last_eval;
    logic             last_bit;
    logic [IDXW-1:0]  next_idx;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input logic [IDXW-1:0] n);
        logic [2*WIDTH-1:0] d;
        d = {v, v} << n;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    // A timed-out evaluation resolves as a 0 vote.
    always_comb begin
        r_ok  = 1'b0;
        r_bit = 1'b0;
        if (puf_done) begin
            r_ok  = 1'b1;
            r_bit = puf_resp;
        end else if (timer == TW'(TIMEOUT - 1)) begin
            r_ok = 1'b1;
        end
    end

    assign vote      = vote_cnt + {3'b000, r_bit};
    assign last_eval = (eval_cnt == 4'(EVALS - 1));
    assign last_bit  = (bit_idx == IDXW'(WIDTH - 1));
    assign next_idx  = last_eval ? bit_idx + IDXW'(1) : bit_idx;

    // The challenge and start strobe are registered on entry to APPLY so the
    // PUF sees them during APPLY and can answer in the first WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            s_ready       <= 1'b1;
            m_valid       <= 1'b0;
            m_data        <= '0;
            puf_start     <= 1'b0;
            puf_challenge <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            chal          <= '0;
            resp          <= '0;
            bit_idx       <= '0;
            eval_cnt      <= '0;
            vote_cnt      <= '0;
            timer         <= '0;
        end else begin
            puf_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        chal          <= s_data;
                        bit_idx       <= '0;
                        eval_cnt      <= '0;
                        vote_cnt      <= '0;
                        resp          <= '0;
                        timeout_err   <= 1'b0;
                        puf_challenge <= s_data;
                        puf_start     <= 1'b1;
                        s_ready       <= 1'b0;
                        busy          <= 1'b1;
                        state         <= APPLY;
                    end
                end
                APPLY: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (r_ok) begin
                        if (!puf_done) timeout_err <= 1'b1;
                        if (!last_eval) begin
                            vote_cnt <= vote;
                            eval_cnt <= eval_cnt + 4'd1;
                        end else begin
                            resp[bit_idx] <= (vote > 4'(EVALS / 2));
                            eval_cnt      <= '0;
                            vote_cnt      <= '0;
                        end
                        if (last_eval && last_bit) begin
                            state <= SEND;
                        end else begin
                            bit_idx       <= next_idx;
                            puf_challenge <= rotl(chal, next_idx);
                            puf_start     <= 1'b1;
                            state         <= APPLY;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SEND: begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= resp;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
